// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 static/PWM output channels driven by one shared 8-bit PWM
// wave. The duty cycle is double-buffered and swapped only at the period wrap,
// so a duty update never truncates or stretches a period.

package pwm_pkg;
  // Per-channel configuration: eo=0 forces low, eo=1/ep=0 static high,
  // eo=1/ep=1 follows the shared PWM wave.
  typedef struct packed {
    logic eo;
    logic ep;
  } chan_cfg_t;
endpackage

// One output channel: registered so every output changes only on clk edges.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  chan_cfg_t cfg,
  input  logic      pwm_raw,
  output logic      out_bit
);

  // Select forced-low / static-high / PWM and register the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_bit <= 1'b0;
    else        out_bit <= cfg.eo & (~cfg.ep | pwm_raw);
  end

endmodule

module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_sync
);

  localparam int NUM_CH = 16;
  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     presc_cnt;
  logic              tick;
  logic [7:0]        pwm_cnt;
  logic [7:0]        duty_act;
  logic              boundary;
  logic              pwm_raw;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  chan_cfg_t [NUM_CH-1:0] cfg;

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick     = (presc_cnt == PW'(PRESCALE - 1));
  // Last count of the period: the edge at which pwm_cnt wraps to 0
  assign boundary = tick && (pwm_cnt == 8'hFF);

  // Prescaler: PRESCALE clk cycles per PWM count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + PW'(1);
  end

  // Period counter: free-running, wraps 255 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pwm_cnt <= 8'h00;
    else if (tick) pwm_cnt <= pwm_cnt + 8'h01;
  end

  // Duty shadow: only the value present at the wrap edge is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        duty_act <= 8'h00;
    else if (boundary) duty_act <= pwm_duty_cycle;
  end

  // Period-start pulse, aligned with the first cycle of pwm_cnt == 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_sync <= 1'b0;
    else        pwm_sync <= boundary;
  end

  // Shared wave: 255 is a true 100% (compare alone would give 255/256)
  always_comb begin
    pwm_raw = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign cfg[i] = '{eo: en_out[i], ep: en_pwm[i]};
      pwm_channel u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg[i]),
        .pwm_raw (pwm_raw),
        .out_bit (out[i])
      );
    end
  endgenerate

endmodule
